// File: rtl/seg_display_pkg.sv
// Shared definitions for the 4-digit display scheduler: FSM states, glyph codes
// and the active-low segment patterns (bit6=a ... bit0=g).
package seg_display_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCORE = 3'd1,
    S_YOU   = 3'd2,
    S_GAP1  = 3'd3,
    S_LOSE  = 3'd4,
    S_GAP2  = 3'd5
  } state_e;

  // Digit glyphs share their BCD value so a valid nibble maps straight to a code.
  typedef enum logic [4:0] {
    G_0 = 5'd0, G_1 = 5'd1, G_2 = 5'd2, G_3 = 5'd3, G_4 = 5'd4,
    G_5 = 5'd5, G_6 = 5'd6, G_7 = 5'd7, G_8 = 5'd8, G_9 = 5'd9,
    G_Y = 5'd10, G_O = 5'd11, G_U = 5'd12, G_L = 5'd13, G_S = 5'd14,
    G_E = 5'd15, G_DASH = 5'd16, G_BLANK = 5'd17
  } glyph_e;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_Y     = 7'b1000100;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic is_msg(input state_e s);
    return s inside {S_YOU, S_GAP1, S_LOSE, S_GAP2};
  endfunction

  // Index 0 is the leftmost digit, driven by anode bit 3.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b0111;
      2'd1:    return 4'b1011;
      2'd2:    return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational glyph-code to active-low 7-segment pattern lookup.
module seg_glyph_decoder
  import seg_display_pkg::*;
(
  input  logic [4:0] glyph_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    case (glyph_i)
      G_0:     seg_n_o = SEG_0;
      G_1:     seg_n_o = SEG_1;
      G_2:     seg_n_o = SEG_2;
      G_3:     seg_n_o = SEG_3;
      G_4:     seg_n_o = SEG_4;
      G_5:     seg_n_o = SEG_5;
      G_6:     seg_n_o = SEG_6;
      G_7:     seg_n_o = SEG_7;
      G_8:     seg_n_o = SEG_8;
      G_9:     seg_n_o = SEG_9;
      G_Y:     seg_n_o = SEG_Y;
      G_O:     seg_n_o = SEG_O;
      G_U:     seg_n_o = SEG_U;
      G_L:     seg_n_o = SEG_L;
      G_S:     seg_n_o = SEG_S;
      G_E:     seg_n_o = SEG_E;
      G_DASH:  seg_n_o = SEG_DASH;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Multiplexed 4-digit display driver: scans digits, runs the game-mode FSM and
// selects idle dashes, blanked score or the blinking YOU/LOSE message.
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        playing,
  input  logic        lost,
  input  logic        score_load,
  input  logic [15:0] score_bcd,
  output logic [3:0]  anode_n,
  output logic [6:0]  seg_n,
  output logic [2:0]  msg_phase
);

  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  state_e                  state_q, state_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [1:0]              idx_q, idx_d;
  logic [BLINK_W-1:0]      blink_q, blink_d;
  logic [15:0]             score_q, score_d;
  logic [3:0]              anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic [4:0]              glyph_d;
  logic [3:0]              cur_nib;
  logic                    lead_blank;
  logic                    scan_tick, blink_tick;

  assign scan_tick  = &scan_q;
  assign blink_tick = is_msg(state_q) && (blink_q == BLINK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (lost) begin
      case (state_q)
        S_IDLE, S_SCORE: state_d = S_YOU;
        S_YOU:           if (blink_tick) state_d = S_GAP1;
        S_GAP1:          if (blink_tick) state_d = S_LOSE;
        S_LOSE:          if (blink_tick) state_d = S_GAP2;
        S_GAP2:          if (blink_tick) state_d = S_YOU;
        default:         state_d = S_IDLE;
      endcase
    end else begin
      state_d = playing ? S_SCORE : S_IDLE;
    end
  end

  // Blink counter only advances while a message stays up; any exit or entry restarts it.
  always_comb begin
    scan_d  = scan_q + REFRESH_BITS'(1);
    idx_d   = scan_tick ? idx_q + 2'd1 : idx_q;
    blink_d = (is_msg(state_q) && lost && !blink_tick) ? blink_q + BLINK_W'(1) : '0;
    score_d = score_load ? score_bcd : score_q;
  end

  // Content is chosen from next-state values so index and mode change together.
  always_comb begin
    cur_nib    = score_d[3:0];
    lead_blank = 1'b0;
    case (idx_d)
      2'd0: begin
        cur_nib    = score_d[15:12];
        lead_blank = (score_d[15:12] == 4'd0);
      end
      2'd1: begin
        cur_nib    = score_d[11:8];
        lead_blank = (score_d[15:8] == 8'd0);
      end
      2'd2: begin
        cur_nib    = score_d[7:4];
        lead_blank = (score_d[15:4] == 12'd0);
      end
      default: begin
        cur_nib    = score_d[3:0];
        lead_blank = 1'b0;
      end
    endcase

    glyph_d = G_BLANK;
    case (state_d)
      S_IDLE:  glyph_d = G_DASH;
      S_SCORE: begin
        if (lead_blank)        glyph_d = G_BLANK;
        else if (cur_nib > 4'd9) glyph_d = G_DASH;
        else                   glyph_d = {1'b0, cur_nib};
      end
      S_YOU: begin
        case (idx_d)
          2'd0:    glyph_d = G_BLANK;
          2'd1:    glyph_d = G_Y;
          2'd2:    glyph_d = G_O;
          default: glyph_d = G_U;
        endcase
      end
      S_LOSE: begin
        case (idx_d)
          2'd0:    glyph_d = G_L;
          2'd1:    glyph_d = G_O;
          2'd2:    glyph_d = G_S;
          default: glyph_d = G_E;
        endcase
      end
      default: glyph_d = G_BLANK;
    endcase

    anode_d = anode_for(idx_d);
  end

  seg_glyph_decoder u_decoder (
    .glyph_i (glyph_d),
    .seg_n_o (seg_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q  <= '0;
      idx_q   <= 2'd0;
      blink_q <= '0;
      score_q <= 16'd0;
      anode_q <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      score_q <= score_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign anode_n   = anode_q;
  assign seg_n     = seg_q;
  assign msg_phase = state_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler with a 4-clock digit step and 16-clock blink phase.
module tb_seg_display_scheduler;
  import seg_display_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, playing, lost, score_load;
  logic [15:0] score_bcd;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic [2:0]  msg_phase;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] st;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          k = 0;
  logic [15:0] exp_score = 16'd0;

  seg_display_scheduler #(.REFRESH_BITS(2), .BLINK_DIV(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .playing    (playing),
    .lost       (lost),
    .score_load (score_load),
    .score_bcd  (score_bcd),
    .anode_n    (anode_n),
    .seg_n      (seg_n),
    .msg_phase  (msg_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, want);
    end
  endtask

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    case (idx)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [2:0] st, input int idx, input logic [15:0] sc);
    logic       lead;
    logic [3:0] nib;
    case (st)
      S_IDLE: return 7'b1111110;
      S_SCORE: begin
        lead = 1'b1;
        for (int j = 0; j < idx; j++) begin
          nib = sc[15-4*j -: 4];
          if (nib != 4'd0) lead = 1'b0;
        end
        nib = sc[15-4*idx -: 4];
        if (lead && nib == 4'd0 && idx < 3) return 7'b1111111;
        return digit_seg(nib);
      end
      S_YOU: begin
        case (idx)
          0: return 7'b1111111;
          1: return 7'b1000100;
          2: return 7'b0000001;
          default: return 7'b1000001;
        endcase
      end
      S_LOSE: begin
        case (idx)
          0: return 7'b1110001;
          1: return 7'b0000001;
          2: return 7'b0100100;
          default: return 7'b0110000;
        endcase
      end
      default: return 7'b1111111;
    endcase
  endfunction

  // One clock edge with the currently driven inputs; queue what the display must show after it.
  task automatic step(input logic [2:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      k = 0;
      exp_score = 16'd0;
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.st  = S_IDLE;
    end else begin
      k++;
      if (score_load) exp_score = score_bcd;
      e.an  = exp_an((k / 4) % 4);
      e.seg = exp_seg(st, (k / 4) % 4, exp_score);
      e.st  = st;
    end
    sb_q.push_back(e);
  endtask

  task automatic run(input int n, input logic [2:0] st);
    for (int i = 0; i < n; i++) step(st);
  endtask

  task automatic load_and_show(input logic [15:0] v);
    score_load = 1'b1;
    score_bcd  = v;
    run(1, S_SCORE);
    score_load = 1'b0;
    run(16, S_SCORE);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("anode_n", 32'(anode_n), 32'(e.an));
      check("seg_n", 32'(seg_n), 32'(e.seg));
      check("msg_phase", 32'(msg_phase), 32'(e.st));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; playing = 1'b0; lost = 1'b0; score_load = 1'b0; score_bcd = 16'd0;
    run(2, S_IDLE);
    rst_n = 1'b1;
    run(16, S_IDLE);

    playing = 1'b1;
    load_and_show(16'h0047);
    load_and_show(16'h0000);
    load_and_show(16'h0A05);

    // lost wins over playing; a score captured during the message appears afterwards
    lost = 1'b1;
    run(16, S_YOU);
    run(16, S_GAP1);
    run(4, S_LOSE);
    score_load = 1'b1; score_bcd = 16'h0012;
    run(1, S_LOSE);
    score_load = 1'b0;
    run(11, S_LOSE);
    run(16, S_GAP2);
    run(16, S_YOU);
    run(5, S_GAP1);
    lost = 1'b0;
    run(16, S_SCORE);

    lost = 1'b1;
    run(16, S_YOU);
    run(3, S_GAP1);
    lost = 1'b0; playing = 1'b0;
    run(4, S_IDLE);

    // reset in the middle of the LOSE message while digit 2 is lit
    playing = 1'b1; lost = 1'b1;
    run(16, S_YOU);
    run(16, S_GAP1);
    run(1, S_LOSE);
    for (int i = 0; i < 15 && ((k / 4) % 4) != 2; i++) run(1, S_LOSE);
    rst_n = 1'b0; lost = 1'b0;
    run(1, S_IDLE);
    rst_n = 1'b1;
    run(16, S_SCORE);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
